// File: rtl/terrain_arb_pkg.sv
// Shared types for the terrain/grass BRAM arbiter.
// Holds the FSM state, the grant encoding and the read-return tag.
package terrain_arb_pkg;

    typedef enum logic {
        ST_ARB,
        ST_FILL
    } state_t;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_VID,
        GNT_WR,
        GNT_RD,
        GNT_FILL
    } grant_t;

    typedef struct packed {
        logic vid;
        logic rd;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/terrain_arb_tag_pipe.sv
// Fixed-depth shift register carrying read-return tags.
// Cleared asynchronously so no stale return survives a reset.
module terrain_arb_tag_pipe #(
    parameter int LAT = 2,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[LAT-1];

endmodule

// File: rtl/terrain_ram_arbiter.sv
// Single-port terrain BRAM arbiter: video > writer/reader (round robin) + fill.
// Define TERRAIN_ARB_STARVE_MON_EN to add the sticky starvation monitor.
module terrain_ram_arbiter
    import terrain_arb_pkg::*;
#(
    parameter int DEPTH  = 3680,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 1,
    parameter int RD_LAT = 2
`ifdef TERRAIN_ARB_STARVE_MON_EN
    ,parameter int STARVE_LIMIT = 1024
`endif
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              vid_req_in,
    input  logic [ADDR_W-1:0] vid_addr_in,
    output logic              vid_valid_out,
    output logic [DATA_W-1:0] vid_data_out,
    input  logic              wr_valid_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ready_out,
    input  logic              rd_valid_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_ready_out,
    output logic              rd_data_valid_out,
    output logic [DATA_W-1:0] rd_data_out,
    input  logic              fill_start_in,
    input  logic [DATA_W-1:0] fill_value_in,
    output logic              fill_busy_out,
    output logic              fill_done_out,
    output logic              ram_en_out,
    output logic              ram_we_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_din_out,
    input  logic [DATA_W-1:0] ram_dout_in
`ifdef TERRAIN_ARB_STARVE_MON_EN
    ,output logic             starve_out
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam int PW = TAG_W + 1 + DATA_W;

    state_t            state, state_nxt;
    grant_t            gnt;
    logic [ADDR_W-1:0] fill_addr;
    logic              rr_wr, fill_done;
    logic [DATA_W-1:0] vid_hold, rd_hold;
    logic              vid_oor, wr_oor, rd_oor;
    tag_t              push_tag, pop_tag;
    logic              push_ovr, pop_ovr;
    logic [DATA_W-1:0] push_val, pop_val;
    logic [PW-1:0]     push, pop;

    assign vid_oor = vid_addr_in > LAST;
    assign wr_oor  = wr_addr_in > LAST;
    assign rd_oor  = rd_addr_in > LAST;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_ARB;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ARB:  if (fill_start_in) state_nxt = ST_FILL;
            ST_FILL: if (fill_addr == LAST) state_nxt = ST_ARB;
        endcase
    end

    // rr_wr set means the writer wins the next writer/reader tie.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst_n_in)                                 gnt = GNT_NONE;
        else if (state == ST_FILL)                     gnt = GNT_FILL;
        else if (vid_req_in)                           gnt = GNT_VID;
        else if (wr_valid_in && (rr_wr || !rd_valid_in)) gnt = GNT_WR;
        else if (rd_valid_in)                          gnt = GNT_RD;
    end

    always_comb begin
        ram_en_out   = 1'b0;
        ram_we_out   = 1'b0;
        ram_addr_out = '0;
        ram_din_out  = '0;
        wr_ready_out = 1'b0;
        rd_ready_out = 1'b0;
        push_tag     = '0;
        push_ovr     = 1'b0;
        push_val     = '0;
        unique case (gnt)
            GNT_FILL: begin
                ram_en_out   = 1'b1;
                ram_we_out   = 1'b1;
                ram_addr_out = fill_addr;
                ram_din_out  = fill_value_in;
                // Video keeps its timing but sees the fill value instead.
                push_tag.vid = vid_req_in;
                push_ovr     = vid_req_in;
                push_val     = fill_value_in;
            end
            GNT_VID: begin
                ram_en_out   = 1'b1;
                ram_addr_out = vid_addr_in;
                push_tag.vid = 1'b1;
                push_ovr     = vid_oor;
            end
            GNT_WR: begin
                ram_en_out   = 1'b1;
                ram_we_out   = !wr_oor;
                ram_addr_out = wr_addr_in;
                ram_din_out  = wr_data_in;
                wr_ready_out = 1'b1;
            end
            GNT_RD: begin
                ram_en_out   = 1'b1;
                ram_addr_out = rd_addr_in;
                rd_ready_out = 1'b1;
                push_tag.rd  = 1'b1;
                push_ovr     = rd_oor;
            end
            default: ;
        endcase
    end

    assign push = {push_tag, push_ovr, push_val};
    assign {pop_tag, pop_ovr, pop_val} = pop;

    terrain_arb_tag_pipe #(
        .LAT (RD_LAT),
        .W   (PW)
    ) u_tag_pipe (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .d     (push),
        .q     (pop)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fill_addr <= '0;
            fill_done <= 1'b0;
            rr_wr     <= 1'b1;
            vid_hold  <= '0;
            rd_hold   <= '0;
        end else begin
            fill_done <= (state == ST_FILL) && (fill_addr == LAST);
            fill_addr <= (state == ST_FILL) ? fill_addr + ADDR_W'(1) : '0;
            if (gnt == GNT_WR)      rr_wr <= 1'b0;
            else if (gnt == GNT_RD) rr_wr <= 1'b1;
            if (vid_valid_out)     vid_hold <= vid_data_out;
            if (rd_data_valid_out) rd_hold  <= rd_data_out;
        end
    end

    assign vid_valid_out     = pop_tag.vid;
    assign rd_data_valid_out = pop_tag.rd;
    assign vid_data_out      = !pop_tag.vid ? vid_hold :
                               pop_ovr      ? pop_val  : ram_dout_in;
    assign rd_data_out       = !pop_tag.rd  ? rd_hold  :
                               pop_ovr      ? pop_val  : ram_dout_in;
    assign fill_busy_out     = state == ST_FILL;
    assign fill_done_out     = fill_done;

`ifdef TERRAIN_ARB_STARVE_MON_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] wr_wait, rd_wait;
    logic          starve;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_wait <= '0;
            rd_wait <= '0;
            starve  <= 1'b0;
        end else begin
            if (gnt == GNT_WR)                      wr_wait <= '0;
            else if (wr_valid_in && wr_wait != LIM) wr_wait <= wr_wait + CW'(1);
            if (gnt == GNT_RD)                      rd_wait <= '0;
            else if (rd_valid_in && rd_wait != LIM) rd_wait <= rd_wait + CW'(1);
            if (wr_wait == LIM || rd_wait == LIM)   starve  <= 1'b1;
        end
    end

    assign starve_out = starve;
`endif

endmodule

// File: tb/tb_terrain_ram_arbiter.sv
// Bench for terrain_ram_arbiter: BRAM model, reference model and directed tests.
// The reference keeps a shadow memory and a queue of pending read returns.
module tb_terrain_ram_arbiter;

    localparam int DEPTH = 3680;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_req, wr_valid, rd_valid, fill_start;
    logic [15:0] vid_addr, wr_addr, rd_addr;
    logic        wr_data, fill_value;
    logic        vid_valid, vid_data, wr_ready, rd_ready;
    logic        rd_data_valid, rd_data, fill_busy, fill_done;
    logic        ram_en, ram_we, ram_din;
    logic [15:0] ram_addr;

    bit          bram [65536];
    bit          bram_s1, ram_dout;
    logic        pl_en, pl_val;
    logic [15:0] pl_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    terrain_ram_arbiter dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .vid_req_in        (vid_req),
        .vid_addr_in       (vid_addr),
        .vid_valid_out     (vid_valid),
        .vid_data_out      (vid_data),
        .wr_valid_in       (wr_valid),
        .wr_addr_in        (wr_addr),
        .wr_data_in        (wr_data),
        .wr_ready_out      (wr_ready),
        .rd_valid_in       (rd_valid),
        .rd_addr_in        (rd_addr),
        .rd_ready_out      (rd_ready),
        .rd_data_valid_out (rd_data_valid),
        .rd_data_out       (rd_data),
        .fill_start_in     (fill_start),
        .fill_value_in     (fill_value),
        .fill_busy_out     (fill_busy),
        .fill_done_out     (fill_done),
        .ram_en_out        (ram_en),
        .ram_we_out        (ram_we),
        .ram_addr_out      (ram_addr),
        .ram_din_out       (ram_din),
        .ram_dout_in       (ram_dout)
    );

    // Read-first BRAM with two cycles of read latency.
    always @(posedge clk) begin
        if (pl_en) bram[pl_addr] <= pl_val;
        else if (ram_en && ram_we) bram[ram_addr] <= ram_din;
        if (ram_en) bram_s1 <= bram[ram_addr];
        ram_dout <= bram_s1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int due;
        bit is_vid;
        bit val;
    } ret_t;

    ret_t rq[$];
    bit   ref_mem [DEPTH];
    int   cyc = 0;
    int   fill_left = 0;
    int   done_cyc = -1;
    bit   pref_wr = 1'b1;
    bit   last_vid = 1'b0;
    bit   last_rd = 1'b0;

    always @(negedge clk) begin : model
        bit   gv, gw, gr, fl, ev, er, evd, erd;
        ret_t r;
        if (!rst_n) begin
            chk("rst_vid_valid", vid_valid, 0);
            chk("rst_rd_valid", rd_data_valid, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_rd_ready", rd_ready, 0);
            chk("rst_busy", fill_busy, 0);
            chk("rst_done", fill_done, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_vid_data", vid_data, 0);
            chk("rst_rd_data", rd_data, 0);
            rq.delete();
            fill_left = 0;
            done_cyc  = -1;
            pref_wr   = 1'b1;
            last_vid  = 1'b0;
            last_rd   = 1'b0;
        end else begin
            fl = fill_left > 0;
            gv = 0; gw = 0; gr = 0;
            if (!fl && vid_req) gv = 1;
            else if (!fl && wr_valid && rd_valid) begin
                if (pref_wr) gw = 1;
                else         gr = 1;
            end else if (!fl) begin
                gw = wr_valid;
                gr = rd_valid;
            end
            chk("wr_ready", wr_ready, gw);
            chk("rd_ready", rd_ready, gr);
            chk("fill_busy", fill_busy, fl);
            chk("fill_done", fill_done, cyc == done_cyc);
            chk("ram_en", ram_en, fl | gv | gw | gr);
            chk("ram_we", ram_we, fl | (gw && wr_addr < DEPTH));
            if (fl) begin
                chk("fill_addr", ram_addr, DEPTH - fill_left);
                chk("fill_din", ram_din, fill_value);
            end
            if (gv) chk("vid_ram_addr", ram_addr, vid_addr);
            if (gr) chk("rd_ram_addr", ram_addr, rd_addr);
            if (gw) begin
                chk("wr_ram_addr", ram_addr, wr_addr);
                chk("wr_ram_din", ram_din, wr_data);
            end
            ev = 0; er = 0; evd = last_vid; erd = last_rd;
            while (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                if (r.is_vid) begin ev = 1; evd = r.val; end
                else          begin er = 1; erd = r.val; end
            end
            chk("vid_valid", vid_valid, ev);
            chk("vid_data", vid_data, evd);
            chk("rd_valid", rd_data_valid, er);
            chk("rd_data", rd_data, erd);
            last_vid = evd;
            last_rd  = erd;
            if (gv) rq.push_back('{cyc + 2, 1'b1,
                                   vid_addr < DEPTH ? ref_mem[vid_addr] : 1'b0});
            if (fl && vid_req) rq.push_back('{cyc + 2, 1'b1, fill_value});
            if (gr) rq.push_back('{cyc + 2, 1'b0,
                                   rd_addr < DEPTH ? ref_mem[rd_addr] : 1'b0});
            if (gw && wr_addr < DEPTH) ref_mem[wr_addr] = wr_data;
            if (gw) pref_wr = 1'b0;
            if (gr) pref_wr = 1'b1;
            if (fl) begin
                ref_mem[DEPTH - fill_left] = fill_value;
                fill_left--;
                if (fill_left == 0) done_cyc = cyc + 1;
            end else if (fill_start) begin
                fill_left = DEPTH;
            end
            if (pl_en && pl_addr < DEPTH) ref_mem[pl_addr] = pl_val;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_val  = v;
        step();
        pl_en   = 1'b0;
    endtask

    task automatic do_rd(input logic [15:0] a, output logic d);
        int n;
        rd_valid = 1'b1;
        rd_addr  = a;
        n = 0;
        @(negedge clk);
        while (!rd_ready && n < 5000) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("rd_accept_timeout", n < 5000, 1);
        step();
        rd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rd_data_valid && n < 10) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("rd_return_timeout", n < 10, 1);
        d = rd_data;
        step();
    endtask

    initial begin
        int   busy_n, done_n, wrf_n;
        logic d;
        rst_n = 0; vid_req = 0; wr_valid = 0; rd_valid = 0; fill_start = 0;
        vid_addr = 0; wr_addr = 0; rd_addr = 0; wr_data = 0; fill_value = 0;
        pl_en = 0; pl_addr = 0; pl_val = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        step();

        // Video only, addresses 0,1,2 holding 1,0,1.
        preload(0, 1); preload(1, 0); preload(2, 1); preload(4000, 1);
        vid_req = 1; vid_addr = 0;
        step(); vid_addr = 1;
        step(); vid_addr = 2;
        @(negedge clk);
        chk("t1_valid0", vid_valid, 1);
        chk("t1_data0", vid_data, 1);
        step(); vid_req = 0;
        @(negedge clk);
        chk("t1_data1", vid_data, 0);
        step();
        @(negedge clk);
        chk("t1_data2", vid_data, 1);
        step();
        @(negedge clk);
        chk("t1_idle_valid", vid_valid, 0);
        chk("t1_hold", vid_data, 1);
        step();

        // Video blocks the writer for five cycles.
        vid_req = 1; vid_addr = 0;
        wr_valid = 1; wr_addr = 5; wr_data = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_wr_blocked", wr_ready, 0);
            step();
        end
        vid_req = 0;
        @(negedge clk);
        chk("t2_wr_granted", wr_ready, 1);
        step();
        wr_valid = 0;
        @(negedge clk);
        chk("t2_vid_valid", vid_valid, 1);
        chk("t2_vid_data", vid_data, 1);
        step();
        do_rd(5, d);
        chk("t2_write_landed", d, 1);

        // Writer and reader contend: WR, RD, WR, RD.
        wr_valid = 1; wr_addr = 10; wr_data = 1;
        rd_valid = 1; rd_addr = 10;
        @(negedge clk);
        chk("t3_c0_wr", wr_ready, 1); chk("t3_c0_rd", rd_ready, 0);
        step();
        @(negedge clk);
        chk("t3_c1_wr", wr_ready, 0); chk("t3_c1_rd", rd_ready, 1);
        step();
        @(negedge clk);
        chk("t3_c2_wr", wr_ready, 1); chk("t3_c2_rd", rd_ready, 0);
        step();
        @(negedge clk);
        chk("t3_c3_wr", wr_ready, 0); chk("t3_c3_rd", rd_ready, 1);
        chk("t3_c3_rvalid", rd_data_valid, 1);
        chk("t3_c3_rdata", rd_data, 1);
        step();
        wr_valid = 0; rd_valid = 0;
        step();
        @(negedge clk);
        chk("t3_c5_rvalid", rd_data_valid, 1);
        step();

        // Out-of-range write is accepted but dropped; read returns 0.
        wr_valid = 1; wr_addr = 4000; wr_data = 1;
        @(negedge clk);
        chk("t6_wr_ready", wr_ready, 1);
        chk("t6_ram_we", ram_we, 0);
        chk("t6_ram_en", ram_en, 1);
        step();
        wr_valid = 0;
        do_rd(4000, d);
        chk("t6_oor_read", d, 0);

        // Full fill with value 1, video and writer active meanwhile.
        fill_value = 1; fill_start = 1;
        step();
        fill_start = 0;
        vid_req = 1; vid_addr = 3000;
        wr_valid = 1; wr_addr = 7; wr_data = 0;
        busy_n = 0; done_n = 0; wrf_n = 0;
        for (int i = 0; i < 3690; i++) begin
            @(negedge clk);
            if (fill_busy) begin
                busy_n++;
                if (wr_ready) wrf_n++;
            end
            if (fill_done) done_n++;
            if (i == 2) begin
                chk("t4_vid_valid", vid_valid, 1);
                chk("t4_vid_fill", vid_data, 1);
            end
            step();
            if (i == 2) vid_req = 0;
        end
        wr_valid = 0;
        chk("t4_busy_cycles", busy_n, 3680);
        chk("t4_done_pulses", done_n, 1);
        chk("t4_wr_during_fill", wrf_n, 0);
        do_rd(3679, d);
        chk("t4_last_addr", d, 1);
        do_rd(1, d);
        chk("t4_addr1", d, 1);

        // Reset while the fill is writing address 100.
        fill_value = 0; fill_start = 1;
        step();
        fill_start = 0;
        repeat (100) step();
        rst_n = 0;
        #1;
        chk("t5_busy", fill_busy, 0);
        chk("t5_ram_en", ram_en, 0);
        chk("t5_ram_we", ram_we, 0);
        chk("t5_ram_addr", ram_addr, 0);
        chk("t5_done", fill_done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            done_n += int'(fill_done);
            busy_n += int'(fill_busy);
            step();
        end
        chk("t5_no_done", done_n, 0);
        chk("t5_arb_state", busy_n, 0);
        do_rd(99, d);
        chk("t5_addr99", d, 0);
        do_rd(100, d);
        chk("t5_addr100", d, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
